// File: rtl/pulse_distributor.sv
// Splits one synchronous pulse stream across two outputs with per-output pending buffers and pulse spacing.
// Optional trace messages on sep_err and drop events when PULSE_DISTRIBUTOR_TRACE_EN is defined.
module pulse_distributor #(
    parameter int T_SEP  = 10,
    parameter int T_IN   = 4,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in,
    input  logic [1:0]        mode,
    input  logic              clr,
    output logic              out1,
    output logic              out2,
    output logic              busy,
    output logic              sep_err,
    output logic              ovf,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int TW = $clog2(T_SEP);
    localparam int SW = $clog2(T_IN + 1);
    localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(T_SEP - 1);
    localparam logic [SW-1:0] TIN_C = SW'(T_IN);

    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [1:0] b);
        logic [DROP_W:0] s;
        s = {1'b0, a} + (DROP_W + 1)'(b);
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

    logic          in_q;
    logic          ptr;
    logic [3:0]    pend    [2];
    logic [3:0]    pend_nx [2];
    logic [TW-1:0] tmr     [2];
    logic [SW-1:0] sp_cnt;
    logic [1:0]    out_q;
    logic          edge_det;
    logic          sep_ev;
    logic [1:0]    push;
    logic [1:0]    iss;
    logic [1:0]    drop;
    logic [1:0]    n_drop;

    always_comb begin
        edge_det = in & ~in_q;
        sep_ev   = edge_det && (sp_cnt < TIN_C);
        push[0]  = edge_det && ((mode == 2'd0) ? ~ptr : (mode == 2'd1 || mode == 2'd3));
        push[1]  = edge_det && ((mode == 2'd0) ?  ptr : (mode == 2'd2 || mode == 2'd3));
        // An issue on the same edge frees a slot, so a full buffer still accepts the push.
        for (int i = 0; i < 2; i++) begin
            iss[i]     = (pend[i] != 4'd0) && (tmr[i] == '0);
            drop[i]    = push[i] && (pend[i] == DEPTH_C) && !iss[i];
            pend_nx[i] = pend[i];
            if (push[i] && !drop[i]) pend_nx[i] = pend_nx[i] + 4'd1;
            if (iss[i])              pend_nx[i] = pend_nx[i] - 4'd1;
        end
        n_drop = {1'b0, drop[0]} + {1'b0, drop[1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q     <= 1'b0;
            ptr      <= 1'b0;
            sp_cnt   <= TIN_C;
            out_q    <= 2'b00;
            busy     <= 1'b0;
            sep_err  <= 1'b0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            for (int i = 0; i < 2; i++) begin
                pend[i] <= 4'd0;
                tmr[i]  <= '0;
            end
        end else begin
            in_q <= in;
            if (edge_det && mode == 2'd0) ptr <= ~ptr;
            if (edge_det)             sp_cnt <= '0;
            else if (sp_cnt < TIN_C)  sp_cnt <= sp_cnt + 1'b1;
            for (int i = 0; i < 2; i++) begin
                pend[i]  <= pend_nx[i];
                out_q[i] <= iss[i];
                if (iss[i])              tmr[i] <= TMR_RELOAD;
                else if (tmr[i] != '0)   tmr[i] <= tmr[i] - 1'b1;
            end
            busy <= (pend_nx[0] != 4'd0) || (pend_nx[1] != 4'd0);
            if (clr) begin
                sep_err  <= 1'b0;
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (sep_ev)      sep_err  <= 1'b1;
                if (|drop)       ovf      <= 1'b1;
                drop_cnt <= sat_add(drop_cnt, n_drop);
            end
        end
    end

    assign out1 = out_q[0];
    assign out2 = out_q[1];

`ifdef PULSE_DISTRIBUTOR_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if (sep_ev)
                $display("%m t=%0t sep_err out%0d pend1=%0d pend2=%0d",
                         $time, push[1] ? 2 : 1, pend[0], pend[1]);
            for (int i = 0; i < 2; i++)
                if (drop[i])
                    $display("%m t=%0t drop out%0d pend=%0d", $time, i + 1, pend[i]);
        end
    end
`else
`endif

endmodule

// File: tb/tb_pulse_distributor.sv
// Directed bench for pulse_distributor (T_SEP=10, T_IN=4, DEPTH=4, DROP_W=2).
module tb_pulse_distributor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in;
    logic [1:0] mode;
    logic       clr;
    logic       out1, out2, busy, sep_err, ovf;
    logic [1:0] drop_cnt;

    int vectors = 0;
    int miscompares = 0;

    pulse_distributor #(.T_SEP(10), .T_IN(4), .DEPTH(4), .DROP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .clr(clr),
        .out1(out1), .out2(out2), .busy(busy), .sep_err(sep_err),
        .ovf(ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in = 1'b0; mode = 2'd0; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({out1, out2, busy} !== 3'b000) begin miscompares++; $display("FAIL reset_outs: got %b expected 000", {out1, out2, busy}); end
        vectors++; if ({sep_err, ovf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags: got %b expected 00", {sep_err, ovf}); end
        vectors++; if (drop_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_round_robin;
        mode = 2'd0;
        for (int i = 0; i < 3; i++) begin
            in = 1'b1; step; in = 1'b0;
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rr_busy_set[%0d]: got %b expected 1", i, busy); end
            vectors++; if ({out1, out2} !== 2'b00) begin miscompares++; $display("FAIL rr_early[%0d]: got %b expected 00", i, {out1, out2}); end
            step;
            vectors++; if ({out1, out2} !== ((i == 1) ? 2'b01 : 2'b10)) begin miscompares++; $display("FAIL rr_route[%0d]: got %b expected %b", i, {out1, out2}, (i == 1) ? 2'b01 : 2'b10); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_busy_clr[%0d]: got %b expected 0", i, busy); end
            step;
            vectors++; if ({out1, out2} !== 2'b00) begin miscompares++; $display("FAIL rr_one_cycle[%0d]: got %b expected 00", i, {out1, out2}); end
            repeat (17) step;
        end
        vectors++; if ({sep_err, ovf} !== 2'b00) begin miscompares++; $display("FAIL rr_flags: got %b expected 00", {sep_err, ovf}); end
    endtask

    task automatic test_backlog;
        int bad1, bad2;
        bad1 = 0; bad2 = 0;
        mode = 2'd1;
        for (int c = 0; c < 50; c++) begin
            in = (c <= 10) && (c % 2 == 0);
            step;
            if (out1 !== ((c == 1) || (c == 11) || (c == 21) || (c == 31) || (c == 41))) bad1++;
            if (out2 !== 1'b0) bad2++;
            if (c == 0) begin
                vectors++; if ({sep_err, ovf} !== 2'b00) begin miscompares++; $display("FAIL bl_first_edge_flags: got %b expected 00", {sep_err, ovf}); end
            end
            if (c == 2) begin
                vectors++; if (sep_err !== 1'b1) begin miscompares++; $display("FAIL bl_sep_err: got %b expected 1", sep_err); end
            end
            if (c == 8) begin
                vectors++; if ({busy, ovf} !== 2'b10) begin miscompares++; $display("FAIL bl_full_no_drop: got busy,ovf=%b expected 10", {busy, ovf}); end
            end
            if (c == 10) begin
                vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL bl_ovf: got %b expected 1", ovf); end
                vectors++; if (drop_cnt !== 2'd1) begin miscompares++; $display("FAIL bl_drop_cnt: got %0d expected 1", drop_cnt); end
            end
        end
        in = 1'b0;
        vectors++; if (bad1 !== 0) begin miscompares++; $display("FAIL bl_out1_timing: got %0d wrong cycles expected 0", bad1); end
        vectors++; if (bad2 !== 0) begin miscompares++; $display("FAIL bl_out2_quiet: got %0d wrong cycles expected 0", bad2); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bl_drained: got busy=%b expected 0", busy); end
        clr = 1'b1; step; clr = 1'b0;
        vectors++; if ({sep_err, ovf, drop_cnt} !== 4'b0000) begin miscompares++; $display("FAIL bl_clr: got %b expected 0000", {sep_err, ovf, drop_cnt}); end
        repeat (5) step;
    endtask

    task automatic test_level_hold;
        int pulses;
        pulses = 0;
        mode = 2'd0;
        in = 1'b1;
        repeat (30) begin step; pulses += int'(out1) + int'(out2); end
        in = 1'b0;
        repeat (15) begin step; pulses += int'(out1) + int'(out2); end
        vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL level_pulses: got %0d expected 1", pulses); end
        vectors++; if (sep_err !== 1'b0) begin miscompares++; $display("FAIL level_sep_err: got %b expected 0", sep_err); end
    endtask

    task automatic test_mid_reset;
        int pulses;
        pulses = 0;
        mode = 2'd2;
        for (int c = 0; c <= 8; c++) begin
            in = (c <= 6) && (c % 2 == 0);
            step;
            if (c == 1) begin
                vectors++; if (out2 !== 1'b1) begin miscompares++; $display("FAIL mr_first_out2: got %b expected 1", out2); end
            end
        end
        in = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mr_backlog: got busy=%b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if ({out1, out2, busy, sep_err, ovf} !== 5'b00000) begin miscompares++; $display("FAIL mr_async_clear: got %b expected 00000", {out1, out2, busy, sep_err, ovf}); end
        step;
        rst_n = 1'b1;
        repeat (25) begin step; pulses += int'(out1) + int'(out2); end
        vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL mr_no_stale: got %0d pulses expected 0", pulses); end
        mode = 2'd0;
        in = 1'b1; step; in = 1'b0; step;
        vectors++; if ({out1, out2} !== 2'b10) begin miscompares++; $display("FAIL mr_ptr_reset: got %b expected 10", {out1, out2}); end
        repeat (20) step;
    endtask

    task automatic test_broadcast;
        rst_n = 1'b0; step; rst_n = 1'b1; step;
        mode = 2'd3;
        in = 1'b1; step; in = 1'b0; step;
        vectors++; if ({out1, out2} !== 2'b11) begin miscompares++; $display("FAIL bc_both: got %b expected 11", {out1, out2}); end
        repeat (20) step;
        mode = 2'd0;
        in = 1'b1; step; in = 1'b0; step;
        vectors++; if ({out1, out2} !== 2'b10) begin miscompares++; $display("FAIL bc_ptr_kept: got %b expected 10", {out1, out2}); end
        repeat (20) step;
    endtask

    task automatic test_drop_sat;
        int bad;
        bad = 0;
        mode = 2'd1;
        for (int c = 0; c < 85; c++) begin
            in  = ((c <= 24) && (c % 2 == 0)) || (c == 31);
            clr = (c == 24);
            step;
            if (out1 !== ((c == 1) || (c % 10 == 1 && c >= 11 && c <= 71))) bad++;
            if (c == 14) begin
                vectors++; if (drop_cnt !== 2'd2) begin miscompares++; $display("FAIL ds_cnt2: got %0d expected 2", drop_cnt); end
            end
            if (c == 16) begin
                vectors++; if (drop_cnt !== 2'd3) begin miscompares++; $display("FAIL ds_cnt3: got %0d expected 3", drop_cnt); end
            end
            if (c == 20) begin
                vectors++; if ({ovf, drop_cnt} !== 3'b111) begin miscompares++; $display("FAIL ds_saturate: got %b expected 111", {ovf, drop_cnt}); end
            end
            if (c == 24) begin
                vectors++; if ({sep_err, ovf, drop_cnt} !== 4'b0000) begin miscompares++; $display("FAIL ds_clr_priority: got %b expected 0000", {sep_err, ovf, drop_cnt}); end
            end
            if (c == 31) begin
                vectors++; if ({sep_err, ovf, drop_cnt} !== 4'b0000) begin miscompares++; $display("FAIL ds_full_push_issue: got %b expected 0000", {sep_err, ovf, drop_cnt}); end
            end
        end
        in = 1'b0; clr = 1'b0;
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL ds_out1_timing: got %0d wrong cycles expected 0", bad); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ds_drained: got busy=%b expected 0", busy); end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_backlog;
        test_level_hold;
        test_mid_reset;
        test_broadcast;
        test_drop_sat;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
